// File: rtl/uart_prog_loader_pkg.sv
// Shared constants for the UART program loader: frame header bytes and FSM encodings.
// Imported by the RX front end and the frame FSM so both agree on encodings.
package uart_prog_loader_pkg;

  localparam logic [7:0] HDR_INSTR = 8'hA5;
  localparam logic [7:0] HDR_DATA  = 8'h5A;

  typedef enum logic [2:0] {
    IDLE,
    CNT_LO,
    CNT_HI,
    DATA,
    WRITE,
    DONE,
    ERR
  } ld_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_BITS,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-flop synchroniser; byte_valid pulses at the mid-point of the stop bit.
// No backpressure: every good byte is presented for exactly one cycle and must be consumed then.
module uart_rx
  import uart_prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       framing_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [1:0]       sync;
  logic             rx_s;
  logic             rx_prev;
  rx_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       idx, idx_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic             vld_nxt, ferr_nxt;

  assign rx_s    = sync[1];
  assign rx_byte = shreg;

  // Synchroniser and edge-detect history reset to the idle (high) line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync        <= 2'b11;
      rx_prev     <= 1'b1;
      state       <= RX_IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      sync        <= {sync[0], rx_in};
      rx_prev     <= rx_s;
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      shreg       <= shreg_nxt;
      byte_valid  <= vld_nxt;
      framing_err <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    vld_nxt   = 1'b0;
    ferr_nxt  = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_nxt = '0;
        if (rx_prev && !rx_s) state_nxt = RX_START;
      end
      RX_START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          // A start bit that has gone high again by mid-bit was noise.
          state_nxt = rx_s ? RX_IDLE : RX_BITS;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RX_BITS: begin
        if (cnt == FULL_LAST) begin
          cnt_nxt   = '0;
          shreg_nxt = {rx_s, shreg[7:1]};
          idx_nxt   = idx + 1'b1;
          if (idx == 3'd7) state_nxt = RX_STOP;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt == FULL_LAST) begin
          cnt_nxt   = '0;
          state_nxt = RX_IDLE;
          vld_nxt   = rx_s;
          ferr_nxt  = !rx_s;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_prog_loader.sv
// Frame FSM that loads instruction/data memory from UART frames while holding the CPU in reset.
// Write strobe lands one cycle after the 4th byte of a word; no backpressure, RX spacing covers the write cycle.
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT_CYC  = 10_000_000,
  parameter int ADDR_W       = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_rx_i,
  input  logic              load_en,
  output logic              cpu_hold,
  output logic              mem_we,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              load_done,
  output logic              load_err
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [7:0]        rx_byte;
  logic              byte_valid;
  logic              framing_err;

  ld_state_t         state, state_nxt;
  logic [15:0]       n_words, n_words_nxt;
  logic [15:0]       word_cnt, word_cnt_nxt;
  logic [15:0]       word_cnt_inc;
  logic [1:0]        byte_idx, byte_idx_nxt;
  logic [23:0]       word_asm, word_asm_nxt;
  logic [ADDR_W-1:0] wptr, wptr_nxt;
  logic [TO_W-1:0]   to_cnt, to_cnt_nxt;
  logic              sel_nxt, err_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [31:0]       wdata_nxt;
  logic              counting, timeout;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rx_in      (uart_rx_i),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .framing_err(framing_err)
  );

  // Strobes decode straight from state so reset clears them asynchronously.
  assign cpu_hold  = (state == CNT_LO) || (state == CNT_HI) || (state == DATA) || (state == WRITE);
  assign mem_we    = (state == WRITE);
  assign load_done = (state == DONE);

  assign counting     = (state == CNT_LO) || (state == CNT_HI) || (state == DATA);
  assign timeout      = counting && !byte_valid && (to_cnt == TO_LAST);
  assign to_cnt_nxt   = (byte_valid || !counting) ? '0 : to_cnt + 1'b1;
  assign word_cnt_inc = word_cnt + 16'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      n_words   <= '0;
      word_cnt  <= '0;
      byte_idx  <= '0;
      word_asm  <= '0;
      wptr      <= '0;
      to_cnt    <= '0;
      mem_sel   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      load_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      n_words   <= n_words_nxt;
      word_cnt  <= word_cnt_nxt;
      byte_idx  <= byte_idx_nxt;
      word_asm  <= word_asm_nxt;
      wptr      <= wptr_nxt;
      to_cnt    <= to_cnt_nxt;
      mem_sel   <= sel_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      load_err  <= err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    n_words_nxt  = n_words;
    word_cnt_nxt = word_cnt;
    byte_idx_nxt = byte_idx;
    word_asm_nxt = word_asm;
    wptr_nxt     = wptr;
    sel_nxt      = mem_sel;
    addr_nxt     = mem_addr;
    wdata_nxt    = mem_wdata;
    err_nxt      = load_err;
    case (state)
      IDLE: begin
        if (byte_valid && load_en && (rx_byte == HDR_INSTR || rx_byte == HDR_DATA)) begin
          state_nxt = CNT_LO;
          sel_nxt   = (rx_byte == HDR_DATA);
          err_nxt   = 1'b0;
        end
      end
      CNT_LO, CNT_HI, DATA, WRITE: begin
        if (!load_en || framing_err || timeout) begin
          state_nxt = ERR;
        end else begin
          case (state)
            CNT_LO: begin
              if (byte_valid) begin
                n_words_nxt[7:0] = rx_byte;
                state_nxt        = CNT_HI;
              end
            end
            CNT_HI: begin
              if (byte_valid) begin
                n_words_nxt  = {rx_byte, n_words[7:0]};
                wptr_nxt     = '0;
                byte_idx_nxt = '0;
                word_cnt_nxt = '0;
                state_nxt    = ({rx_byte, n_words[7:0]} == 16'd0) ? DONE : DATA;
              end
            end
            DATA: begin
              if (byte_valid) begin
                byte_idx_nxt = byte_idx + 1'b1;
                case (byte_idx)
                  2'd0: word_asm_nxt[7:0]   = rx_byte;
                  2'd1: word_asm_nxt[15:8]  = rx_byte;
                  2'd2: word_asm_nxt[23:16] = rx_byte;
                  default: begin
                    // Output registers only move here, so they hold between strobes.
                    addr_nxt  = wptr;
                    wdata_nxt = {rx_byte, word_asm};
                    state_nxt = WRITE;
                  end
                endcase
              end
            end
            default: begin
              wptr_nxt     = wptr + 1'b1;
              word_cnt_nxt = word_cnt_inc;
              state_nxt    = (word_cnt_inc == n_words) ? DONE : DATA;
            end
          endcase
        end
      end
      DONE: state_nxt = IDLE;
      ERR: begin
        err_nxt   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader at CLKS_PER_BIT=16, TIMEOUT_CYC=2000.
module tb_uart_prog_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        uart_rx_i = 1'b1;
  logic        load_en = 1'b0;
  logic        cpu_hold, mem_we, mem_sel, load_done, load_err;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;

  int checks = 0;
  int errors = 0;

  int          we_n = 0;
  int          done_n = 0;
  logic [13:0] we_addr [16];
  logic [31:0] we_data [16];
  logic        we_sel  [16];
  logic        hold_prev = 1'b0;
  logic        hold_before_done = 1'b0;
  logic        hold_at_done = 1'b1;

  int          base_we, base_done;
  logic [7:0]  frame [$];

  uart_prog_loader #(
    .CLKS_PER_BIT(16),
    .TIMEOUT_CYC (2000),
    .ADDR_W      (14)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .uart_rx_i(uart_rx_i),
    .load_en  (load_en),
    .cpu_hold (cpu_hold),
    .mem_we   (mem_we),
    .mem_sel  (mem_sel),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .load_done(load_done),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      if (we_n < 16) begin
        we_addr[we_n] = mem_addr;
        we_data[we_n] = mem_wdata;
        we_sel[we_n]  = mem_sel;
      end
      we_n = we_n + 1;
    end
    if (load_done) begin
      done_n           = done_n + 1;
      hold_before_done = hold_prev;
      hold_at_done     = cpu_hold;
    end
    hold_prev = cpu_hold;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx_i = 1'b0;
    idle(16);
    for (int i = 0; i < 8; i++) begin
      uart_rx_i = b[i];
      idle(16);
    end
    uart_rx_i = stop;
    idle(16);
    if (!stop) idle(16);
    uart_rx_i = 1'b1;
    idle(4);
  endtask

  task automatic send_frame(input logic [7:0] q [$]);
    foreach (q[i]) send_byte(q[i], 1'b1);
  endtask

  initial begin
    idle(3);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_sel", 32'(mem_sel), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    reset   = 1'b0;
    load_en = 1'b1;
    idle(5);

    // Two-word instruction frame
    base_we = we_n; base_done = done_n;
    send_byte(8'hA5, 1'b1);
    idle(2);
    chk("a_hold_after_hdr", 32'(cpu_hold), 32'd1);
    frame = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_frame(frame);
    idle(20);
    chk("a_we_count", 32'(we_n - base_we), 32'd2);
    chk("a_addr0", 32'(we_addr[base_we]), 32'd0);
    chk("a_data0", we_data[base_we], 32'h12345678);
    chk("a_sel0", 32'(we_sel[base_we]), 32'd0);
    chk("a_addr1", 32'(we_addr[base_we+1]), 32'd1);
    chk("a_data1", we_data[base_we+1], 32'hDEADBEEF);
    chk("a_sel1", 32'(we_sel[base_we+1]), 32'd0);
    chk("a_done_count", 32'(done_n - base_done), 32'd1);
    chk("a_hold_before_done", 32'(hold_before_done), 32'd1);
    chk("a_hold_at_done", 32'(hold_at_done), 32'd0);
    chk("a_addr_held", 32'(mem_addr), 32'd1);
    chk("a_wdata_held", mem_wdata, 32'hDEADBEEF);

    // Empty data frame
    base_we = we_n; base_done = done_n;
    frame = '{8'h5A, 8'h00, 8'h00};
    send_frame(frame);
    idle(20);
    chk("b_we_count", 32'(we_n - base_we), 32'd0);
    chk("b_done_count", 32'(done_n - base_done), 32'd1);
    chk("b_mem_sel", 32'(mem_sel), 32'd1);
    chk("b_hold", 32'(cpu_hold), 32'd0);

    // Timeout: just before and just after the 2000-cycle limit
    base_we = we_n;
    frame = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
    send_frame(frame);
    idle(1980);
    chk("c_hold_before_to", 32'(cpu_hold), 32'd1);
    chk("c_err_before_to", 32'(load_err), 32'd0);
    idle(30);
    chk("c_err_after_to", 32'(load_err), 32'd1);
    chk("c_hold_after_to", 32'(cpu_hold), 32'd0);
    chk("c_we_count", 32'(we_n - base_we), 32'd0);

    // Framing error on the 4th data byte, then a clean frame
    base_we = we_n;
    frame = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34};
    send_frame(frame);
    send_byte(8'h12, 1'b0);
    idle(10);
    chk("d_err_set", 32'(load_err), 32'd1);
    chk("d_hold_dropped", 32'(cpu_hold), 32'd0);
    chk("d_we_none", 32'(we_n - base_we), 32'd0);
    base_done = done_n;
    send_byte(8'hA5, 1'b1);
    idle(2);
    chk("d_err_cleared", 32'(load_err), 32'd0);
    frame = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_frame(frame);
    idle(20);
    chk("d_we_count", 32'(we_n - base_we), 32'd1);
    chk("d_addr", 32'(we_addr[base_we]), 32'd0);
    chk("d_data", we_data[base_we], 32'hDEADBEEF);
    chk("d_done_count", 32'(done_n - base_done), 32'd1);
    chk("d_err_final", 32'(load_err), 32'd0);

    // Loader disabled, then disabled mid-frame
    load_en = 1'b0;
    base_we = we_n; base_done = done_n;
    send_byte(8'hA5, 1'b1);
    idle(2);
    chk("e_hold_disabled", 32'(cpu_hold), 32'd0);
    frame = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(frame);
    idle(20);
    chk("e_we_none", 32'(we_n - base_we), 32'd0);
    chk("e_done_none", 32'(done_n - base_done), 32'd0);
    chk("e_err_clear", 32'(load_err), 32'd0);
    load_en = 1'b1;
    frame = '{8'hA5, 8'h01, 8'h00, 8'h11};
    send_frame(frame);
    chk("e_hold_midframe", 32'(cpu_hold), 32'd1);
    load_en = 1'b0;
    idle(3);
    chk("e_err_en_drop", 32'(load_err), 32'd1);
    chk("e_hold_en_drop", 32'(cpu_hold), 32'd0);
    load_en = 1'b1;
    idle(5);

    // Asynchronous reset during the second word
    base_we = we_n;
    frame = '{8'h5A, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hBB, 8'hAA};
    send_frame(frame);
    idle(3);
    chk("f_hold_pre_rst", 32'(cpu_hold), 32'd1);
    chk("f_wdata_pre_rst", mem_wdata, 32'h12345678);
    chk("f_sel_pre_rst", 32'(mem_sel), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("f_rst_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("f_rst_mem_we", 32'(mem_we), 32'd0);
    chk("f_rst_mem_sel", 32'(mem_sel), 32'd0);
    chk("f_rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("f_rst_mem_wdata", mem_wdata, 32'd0);
    chk("f_rst_load_done", 32'(load_done), 32'd0);
    chk("f_rst_load_err", 32'(load_err), 32'd0);
    idle(5);
    reset = 1'b0;
    idle(5);
    frame = '{8'hCC, 8'hDD};
    send_frame(frame);
    idle(20);
    chk("f_we_count", 32'(we_n - base_we), 32'd1);
    chk("f_hold_after", 32'(cpu_hold), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
